mem_bank_ctrl: RTL
==================

Name: mem_bank_ctrl

Overview:
Parametrised, clocked successor to the 4-byte switch-addressed memory. It stores DATA_W-bit words at DEPTH addresses, one write per press of the asynchronous store button. The store button is synchronised and edge-detected. After every reset a sweep FSM clears the whole array, and reads are registered. The block sits between the board switches/button and the LED bank in top-level board designs.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 2, address width; DEPTH = 2**ADDR_W words
SYNC_STAGES, 2, flops in the store synchroniser; legal range ≥ 2
CNT_W, 8, width of the accepted-write counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
data  input  DATA_W  write data (switches)
store  input  1  raw asynchronous store button, active-high
addr  input  ADDR_W  shared read/write address
memory  output  DATA_W  registered read data
busy  output  1  high while the clear sweep runs; writes are ignored
wr_count  output  CNT_W  number of accepted writes, modulo 2**CNT_W

Behaviour:
- Reset (rst high at an edge):
  - state <= CLEAR, clr_ptr <= 0, busy <= 1, memory <= 0, wr_count <= 0.
  - All synchroniser and edge-history flops <= 0.
  - Array contents are not reset directly; the sweep clears them.
- Store path:
  - store passes through a SYNC_STAGES-flop chain, then a history flop.
  - wr_pulse = sync_out & ~hist, so one pulse is produced per rising edge of the synchronised store.
  - If store is first sampled high at edge k, wr_pulse is high during the cycle after edge k+SYNC_STAGES-1, and the write commits at edge k+SYNC_STAGES.
  - Holding store high produces exactly one write. A release followed by a new press produces another write.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle, mem[clr_ptr] <= 0 and clr_ptr increments.
    - When clr_ptr == DEPTH-1: write the last word, then state <= IDLE and busy <= 0 at the same edge.
    - busy is high for exactly DEPTH cycles after rst deasserts.
    - memory is held at 0 throughout CLEAR.
    - wr_pulse during CLEAR is dropped: no write, no count, and it is not queued.
  - IDLE:
    - When wr_pulse is high: mem[addr] <= data and wr_count <= wr_count+1. wr_count wraps from 2**CNT_W-1 to 0.
    - memory <= (wr_pulse) ? data : mem[addr]. This is write-first bypass; the read address is always addr.
    - Read latency is 1 cycle from an addr change.
- addr or data changing while store is held causes no further writes.
- rst asserted mid-sweep or in IDLE returns the FSM to CLEAR with clr_ptr = 0, so the sweep restarts from scratch.
- No combinational path from store to any output.

Decomposition:
- Package mem_bank_pkg:
  - state enum {CLEAR, IDLE}
  - localparam function for DEPTH from ADDR_W
  - reset-value constants
- Sub-module btn_sync_edge:
  - parameters SYNC_STAGES
  - ports clk, rst, btn_in, pulse
  - the same sub-module is reusable for other button inputs
- The array, FSM and counter stay in mem_bank_ctrl.

Test Plan:
- Reset, then release → busy high exactly 4 cycles (defaults), then 0. Sweeping addr 0..3 reads 0x00 at each address, and wr_count = 0.
- IDLE, addr=2, data=0xA5, pulse store high for 10 cycles → write lands at edge k+2. memory=0xA5 at that edge, wr_count=1, and no second write occurs while held.
- Writes 0x11, 0x22, 0x33, 0x44 to addr 0..3 (separate presses) → readback in order gives 0x11..0x44 with 1-cycle latency after each addr change, and wr_count=4.
- Press store during the CLEAR sweep → no write, wr_count stays 0, all words read 0x00 after busy falls.
- After the array is filled, assert rst for 1 cycle mid-operation, then again after 2 sweep cycles → the sweep restarts each time, busy lasts 4 cycles after the final rst, and all words read 0.
- CNT_W=2, 5 accepted presses → wr_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/mem_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bank_pkg
//  Description : Shared constants and helpers for the switch-addressed
//                memory bank controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bank_pkg;

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_IDLE  = 1'b1;

    localparam logic [0:0] c_STATE_RESET = c_ST_CLEAR;
    localparam logic       c_BUSY_RESET  = 1'b1;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_sync_edge
//  Description : Synchronises an asynchronous button and emits a one-cycle
//                pulse on each rising edge of the synchronised level.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    // Driven only from flops, so the raw button never reaches the outputs.
    assign pulse = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/mem_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bank_ctrl
//  Description : Button-written word memory with post-reset clear sweep,
//                registered write-first read port and a write counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bank_ctrl
    import mem_bank_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] memory,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int c_DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_busy;
    logic [CNT_W-1:0]  r_wr_count;

    logic              w_wr_pulse;
    logic              w_clr_last;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    btn_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_store_sync (
        .clk    (clk),
        .rst    (rst),
        .btn_in (store),
        .pulse  (w_wr_pulse)
    );

    assign w_clr_last = (r_clr_ptr == {ADDR_W{1'b1}});

    // Single array write port shared by the clear sweep and button writes.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = addr;
        w_mem_wdata = data;
        if (!rst) begin
            if (r_state == c_ST_CLEAR) begin
                w_mem_we    = 1'b1;
                w_mem_waddr = r_clr_ptr;
                w_mem_wdata = '0;
            end else begin
                w_mem_we    = w_wr_pulse;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_STATE_RESET;
            r_clr_ptr  <= '0;
            r_busy     <= c_BUSY_RESET;
            r_rd_data  <= '0;
            r_wr_count <= '0;
        end else begin
            case (r_state)
                c_ST_CLEAR: begin
                    r_rd_data <= '0;
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (w_clr_last) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                c_ST_IDLE: begin
                    r_rd_data <= w_wr_pulse ? data : r_mem[addr];
                    if (w_wr_pulse) begin
                        r_wr_count <= r_wr_count + 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_ST_CLEAR;
                    r_clr_ptr <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign memory   = r_rd_data;
    assign busy     = r_busy;
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire
